// File: rtl/sched_dp_pkg.sv
// sched_dp_pkg: shared constants and control-word layout helpers for the
// self-sequencing scheduled datapath (sched_dp_seq) and its function units.
//
// Contents:
//   - operand source indices (i1, i2, then r0..r(NREGS-1))
//   - opcode constants for the ALU, MUL/DIV and LOG units
//   - function-unit kind identifiers (also the slot order inside a word)
//   - sequencer state encoding
//   - field-width and field-offset functions for control words, so the
//     datapath and any program assembler agree on a single layout
//
// Control word layout, MSB to LSB:
//   { log_field, mul_field, alu_field, last, res_sel }
// Per-FU field layout, MSB to LSB:
//   { sel1, sel2, op[1:0], dst, wen }
package sched_dp_pkg;

    // Operand bus sources. Register rk sits at SRC_R0 + k. Any select value
    // past the last register reads as zero.
    localparam int SRC_I1 = 0;
    localparam int SRC_I2 = 1;
    localparam int SRC_R0 = 2;

    // ALU opcodes
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_SLT  = 2'b10;  // signed set-less-than
    localparam logic [1:0] ALU_PASS = 2'b11;  // pass op1

    // MUL/DIV opcodes (all unsigned)
    localparam logic [1:0] MUL_LO  = 2'b00;
    localparam logic [1:0] MUL_DIV = 2'b01;
    localparam logic [1:0] MUL_REM = 2'b10;
    localparam logic [1:0] MUL_HI  = 2'b11;

    // Logic-unit opcodes
    localparam logic [1:0] LOG_AND = 2'b00;
    localparam logic [1:0] LOG_OR  = 2'b01;
    localparam logic [1:0] LOG_XOR = 2'b10;
    localparam logic [1:0] LOG_NOT = 2'b11;  // bitwise not of op1

    // Function-unit kinds. The value is also the slot index of the unit's
    // field in a control word, and the write priority order (higher wins).
    localparam int FU_ALU = 0;
    localparam int FU_MUL = 1;
    localparam int FU_LOG = 2;

    // Sequencer state encoding.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // ---------------------------------------------------------------
    // Field widths
    // ---------------------------------------------------------------
    function automatic int sel_w(input int nregs);
        return $clog2(nregs + 2);
    endfunction

    function automatic int dst_w(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int fu_w(input int nregs);
        return 2 * sel_w(nregs) + 2 + dst_w(nregs) + 1;
    endfunction

    function automatic int cw_w(input int nregs);
        return 3 * fu_w(nregs) + 1 + sel_w(nregs);
    endfunction

    // ---------------------------------------------------------------
    // Control-word offsets
    // ---------------------------------------------------------------
    function automatic int cw_res_sel_lsb();
        return 0;
    endfunction

    function automatic int cw_last_bit(input int nregs);
        return sel_w(nregs);
    endfunction

    // kind is FU_ALU, FU_MUL or FU_LOG
    function automatic int cw_fu_lsb(input int nregs, input int kind);
        return sel_w(nregs) + 1 + kind * fu_w(nregs);
    endfunction

    // ---------------------------------------------------------------
    // Offsets inside one FU field
    // ---------------------------------------------------------------
    function automatic int fu_wen_bit();
        return 0;
    endfunction

    function automatic int fu_dst_lsb();
        return 1;
    endfunction

    function automatic int fu_op_lsb(input int nregs);
        return 1 + dst_w(nregs);
    endfunction

    function automatic int fu_sel2_lsb(input int nregs);
        return 3 + dst_w(nregs);
    endfunction

    function automatic int fu_sel1_lsb(input int nregs);
        return 3 + dst_w(nregs) + sel_w(nregs);
    endfunction

endpackage

// File: rtl/sched_dp_fu.sv
// sched_dp_fu: one combinational function unit of the scheduled datapath.
// KIND selects which unit is built (FU_ALU, FU_MUL or FU_LOG).
//
// Ports:
//   op1, op2 : operands (WIDTH bits)
//   op       : 2-bit opcode, meaning depends on KIND
//   res      : result (WIDTH bits), arithmetic wraps modulo 2^WIDTH
//   dz       : high when a divide or remainder op sees a zero divisor
//              (only the MUL kind can raise it)
module sched_dp_fu
    import sched_dp_pkg::*;
#(
    parameter int KIND  = FU_ALU,
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             dz
);

    generate
        if (KIND == FU_ALU) begin : g_alu
            always_comb begin
                res = '0;
                dz  = 1'b0;
                case (op)
                    ALU_ADD: res = op1 + op2;
                    ALU_SUB: res = op1 - op2;
                    ALU_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
                    default: res = op1;
                endcase
            end
        end else if (KIND == FU_MUL) begin : g_mul
            // Full unsigned product; low and high halves serve two opcodes.
            logic [2*WIDTH-1:0] prod;
            logic               div_zero;

            assign prod     = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};
            assign div_zero = (op2 == '0);

            always_comb begin
                res = '0;
                dz  = 1'b0;
                case (op)
                    MUL_LO: res = prod[WIDTH-1:0];
                    MUL_DIV: begin
                        // Zero divisor yields all-ones, like a restoring
                        // divider that never finds a remainder to subtract.
                        if (div_zero) begin
                            res = '1;
                            dz  = 1'b1;
                        end else begin
                            res = op1 / op2;
                        end
                    end
                    MUL_REM: begin
                        if (div_zero) begin
                            res = op1;
                            dz  = 1'b1;
                        end else begin
                            res = op1 % op2;
                        end
                    end
                    default: res = prod[2*WIDTH-1:WIDTH];
                endcase
            end
        end else begin : g_log
            always_comb begin
                res = '0;
                dz  = 1'b0;
                case (op)
                    LOG_AND: res = op1 & op2;
                    LOG_OR:  res = op1 | op2;
                    LOG_XOR: res = op1 ^ op2;
                    default: res = ~op1;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/sched_dp_seq.sv
// sched_dp_seq: self-sequencing scheduled datapath. A DEPTH-word microprogram
// drives an ALU, a MUL/DIV unit and a logic unit that read from an operand
// bus {i1, i2, r0..r(NREGS-1), zeros} and write an NREGS-entry register file.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a run (honoured only when idle)
//   i1, i2       : operands, latched when a start is accepted
//   prog_we      : microprogram write strobe (ignored while busy)
//   prog_addr    : microprogram write address
//   prog_data    : control word to write
//   busy         : high while the program is running
//   done         : one-cycle pulse; result is valid from this cycle on
//   result       : final value, held until the next accepted start
//   dz_err       : sticky, a written divide/remainder saw a zero divisor
//   wr_conflict  : sticky, two units wrote the same register in one step
//   runaway      : sticky, the last word was reached without a last bit
//
// Handshake: start is accepted on any rising edge where busy is low,
// including the edge right after a done pulse. From that edge busy stays
// high for exactly N cycles for an N-word program; done pulses in the cycle
// after busy falls, together with the final result and flags. start while
// busy is ignored and is not remembered. A reset aborts a run with no done.
module sched_dp_seq
    import sched_dp_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 8,
    parameter  int DEPTH = 16,
    localparam int SELW  = $clog2(NREGS + 2),
    localparam int DSTW  = $clog2(NREGS),
    localparam int FUW   = 2 * SELW + 2 + DSTW + 1,
    localparam int CW_W  = 3 * FUW + 1 + SELW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [CW_W-1:0]  prog_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz_err,
    output logic             wr_conflict,
    output logic             runaway
);

    localparam logic [0:0] ST_IDLE = S_IDLE;
    localparam logic [0:0] ST_RUN  = S_RUN;

    // Operand bus is padded to a power of two so every select value indexes
    // a real entry; the padding entries read as zero.
    localparam int NSRC     = 2 ** SELW;
    localparam int LAST_BIT = cw_last_bit(NREGS);
    localparam int RES_LSB  = cw_res_sel_lsb();

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [CW_W-1:0]  mem [DEPTH];
    logic [0:0]       state;
    logic [AW-1:0]    pc;
    logic [WIDTH-1:0] i1_q;
    logic [WIDTH-1:0] i2_q;
    logic [WIDTH-1:0] regs [NREGS];

    // ---------------------------------------------------------------
    // Current word decode
    // ---------------------------------------------------------------
    logic [CW_W-1:0]  cw;
    logic [SELW-1:0]  res_sel;
    logic             last_bit;
    logic             at_end;
    logic             finish;

    logic [SELW-1:0]  sel1   [3];
    logic [SELW-1:0]  sel2   [3];
    logic [1:0]       fu_op  [3];
    logic [DSTW-1:0]  dst    [3];
    logic [2:0]       wen;
    logic [WIDTH-1:0] fu_a   [3];
    logic [WIDTH-1:0] fu_b   [3];
    logic [WIDTH-1:0] fu_res [3];
    logic [2:0]       fu_dz;
    logic             dz_any;
    logic             conflict;

    logic [WIDTH-1:0] bus [NSRC];

    assign cw       = mem[pc];
    assign res_sel  = cw[RES_LSB +: SELW];
    assign last_bit = cw[LAST_BIT];
    assign at_end   = (pc == AW'(DEPTH - 1));
    assign finish   = last_bit || at_end;

    assign busy = (state == ST_RUN);

    // Operand bus: pre-write values only, so a step never sees its own
    // results (no forwarding).
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            bus[s] = '0;
        end
        bus[SRC_I1] = i1_q;
        bus[SRC_I2] = i2_q;
        for (int k = 0; k < NREGS; k++) begin
            bus[SRC_R0 + k] = regs[k];
        end
    end

    // ---------------------------------------------------------------
    // Function units, one per slot of the control word
    // ---------------------------------------------------------------
    generate
        for (genvar k = 0; k < 3; k++) begin : g_fu
            localparam int LSB = cw_fu_lsb(NREGS, k);

            logic [FUW-1:0] fld;

            assign fld      = cw[LSB +: FUW];
            assign wen[k]   = fld[fu_wen_bit()];
            assign dst[k]   = fld[fu_dst_lsb() +: DSTW];
            assign fu_op[k] = fld[fu_op_lsb(NREGS) +: 2];
            assign sel2[k]  = fld[fu_sel2_lsb(NREGS) +: SELW];
            assign sel1[k]  = fld[fu_sel1_lsb(NREGS) +: SELW];
            assign fu_a[k]  = bus[sel1[k]];
            assign fu_b[k]  = bus[sel2[k]];

            sched_dp_fu #(
                .KIND  (k),
                .WIDTH (WIDTH)
            ) u_fu (
                .op1 (fu_a[k]),
                .op2 (fu_b[k]),
                .op  (fu_op[k]),
                .res (fu_res[k]),
                .dz  (fu_dz[k])
            );
        end
    endgenerate

    // A zero divisor only counts when the unit's result is actually written;
    // an idle MUL slot with stale operands must not raise the flag.
    assign dz_any = |(fu_dz & wen);

    assign conflict = (wen[FU_ALU] && wen[FU_MUL] && (dst[FU_ALU] == dst[FU_MUL])) ||
                      (wen[FU_ALU] && wen[FU_LOG] && (dst[FU_ALU] == dst[FU_LOG])) ||
                      (wen[FU_MUL] && wen[FU_LOG] && (dst[FU_MUL] == dst[FU_LOG]));

    // ---------------------------------------------------------------
    // Microprogram memory: no reset, survives rst, frozen while running
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (prog_we && (state == ST_IDLE) && (int'(prog_addr) < DEPTH)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // ---------------------------------------------------------------
    // Sequencer and register file
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            result      <= '0;
            done        <= 1'b0;
            dz_err      <= 1'b0;
            wr_conflict <= 1'b0;
            runaway     <= 1'b0;
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        pc          <= '0;
                        i1_q        <= i1;
                        i2_q        <= i2;
                        dz_err      <= 1'b0;
                        wr_conflict <= 1'b0;
                        runaway     <= 1'b0;
                        for (int k = 0; k < NREGS; k++) begin
                            regs[k] <= '0;
                        end
                    end
                end
                default: begin
                    // Slots are visited ALU, MUL, LOG; the later write to a
                    // shared destination wins, giving LOG > MUL > ALU.
                    for (int k = 0; k < 3; k++) begin
                        if (wen[k] && (int'(dst[k]) < NREGS)) begin
                            regs[dst[k]] <= fu_res[k];
                        end
                    end
                    pc <= pc + AW'(1);
                    if (dz_any) begin
                        dz_err <= 1'b1;
                    end
                    if (conflict) begin
                        wr_conflict <= 1'b1;
                    end
                    if (finish) begin
                        // Result takes the bus value before this step's writes.
                        result <= bus[res_sel];
                        done   <= 1'b1;
                        state  <= ST_IDLE;
                        pc     <= '0;
                        if (!last_bit) begin
                            runaway <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
